// File: rtl/uart_rx.sv
// 8N1 UART receiver.
// Receives bytes from the asynchronous serial line rxd_in, LSB first.
// Each correctly framed byte is shown on data_out, and new_data is raised
// until the consumer pulses read.
// A start bit is confirmed half a bit after the falling edge. Each later bit
// is then sampled one full bit period after the previous one.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1302
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd_in,
  input  logic       read,
  output logic [7:0] data_out,
  output logic       new_data
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       idx_q,   idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q,  data_d;
  logic             new_q,   new_d;
  logic             sync1_q, sync2_q;
  logic             rx;

  // Two-flop synchroniser for the asynchronous line. It resets to the idle
  // (high) level so that leaving reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd_in;
      sync2_q <= sync1_q;
    end
  end

  assign rx = sync2_q;

  // Register for the state, the counters, the shift register and the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      new_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      new_q   <= new_d;
    end
  end

  // Next state and bit sampling. A read clears new_data first. A byte that
  // completes on the same cycle sets it again, so the new byte is not lost.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    new_d   = new_q;

    if (read) begin
      new_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          // A line that is high again at mid-start-bit was only a glitch.
          state_d = rx ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx) begin
            data_d  = shift_q;
            new_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Framing error: drop the byte. Wait for the line to return high
            // so that a stuck-low line cannot start another frame.
            state_d = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data_out = data_q;
  assign new_data = new_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx.
// The bit period is shortened so that every scenario fits in a short run.
// All timings below are scaled from the default rate.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_BIT  = 260;
  localparam int HALF     = CLK_BIT / 2;
  // Edge (counted from the edge before the start bit is driven) on which the
  // stop bit is sampled: 2 synchroniser edges + 1 IDLE edge + half bit
  // + 9 full bits.
  localparam int STOP_EDGE = 3 + HALF + 9 * CLK_BIT;

  logic       clk;
  logic       rst;
  logic       rxd_in;
  logic       read;
  logic [7:0] data_out;
  logic       new_data;

  int checks;
  int failures;

  uart_rx #(.CLKS_PER_BIT(CLK_BIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd_in   (rxd_in),
    .read     (read),
    .data_out (data_out),
    .new_data (new_data)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // The caller must be just after a rising edge. The frame starts at once.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_bits);
    rxd_in = 1'b0;
    repeat (CLK_BIT) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxd_in = b[i];
      repeat (CLK_BIT) @(posedge clk);
      #1;
    end
    rxd_in = stop_bit;
    repeat (CLK_BIT * stop_bits) @(posedge clk);
    #1;
    rxd_in = 1'b1;
  endtask

  task automatic pulse_read();
    @(posedge clk);
    #1 read = 1'b1;
    @(posedge clk);
    #1 read = 1'b0;
  endtask

  initial begin
    logic seen;
    checks   = 0;
    failures = 0;
    rxd_in   = 1'b1;
    read     = 1'b0;
    rst      = 1'b1;
    #1 rst   = 1'b0;

    // Reset values
    #100;
    check_eq("rst_data", data_out, 8'h00);
    check_eq("rst_new", new_data, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    check_eq("idle_data", data_out, 8'h00);
    check_eq("idle_new", new_data, 1'b0);

    // Glitch shorter than half a bit
    rxd_in = 1'b0;
    repeat (HALF - 10) @(posedge clk);
    #1 rxd_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 * CLK_BIT; i++) begin
      @(posedge clk);
      #1;
      if (new_data) seen = 1'b1;
    end
    check_eq("glitch_new", seen, 1'b0);
    check_eq("glitch_data", data_out, 8'h00);

    // Valid byte 0xA5, with exact stop-sample latency
    @(posedge clk);
    #1;
    fork
      send_frame(8'hA5, 1'b1, 1);
      begin
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1;
        check_eq("a5_pre_new", new_data, 1'b0);
        check_eq("a5_pre_data", data_out, 8'h00);
        @(posedge clk);
        #1;
        check_eq("a5_at_new", new_data, 1'b1);
        check_eq("a5_at_data", data_out, 8'hA5);
      end
    join
    repeat (50) @(posedge clk);
    #1;
    check_eq("a5_hold_new", new_data, 1'b1);
    check_eq("a5_hold_data", data_out, 8'hA5);

    // Read handshake
    pulse_read();
    check_eq("rd_new", new_data, 1'b0);
    check_eq("rd_data", data_out, 8'hA5);
    pulse_read();
    check_eq("rd2_new", new_data, 1'b0);
    check_eq("rd2_data", data_out, 8'hA5);

    // Framing error, then a valid 0x5A
    @(posedge clk);
    #1;
    send_frame(8'h3C, 1'b0, 2);
    repeat (3 * CLK_BIT) @(posedge clk);
    #1;
    check_eq("ferr_new", new_data, 1'b0);
    check_eq("ferr_data", data_out, 8'hA5);
    send_frame(8'h5A, 1'b1, 1);
    check_eq("5a_new", new_data, 1'b1);
    check_eq("5a_data", data_out, 8'h5A);
    pulse_read();
    check_eq("5a_rd_new", new_data, 1'b0);

    // Overrun: 0x11 then 0x22 without read
    @(posedge clk);
    #1;
    send_frame(8'h11, 1'b1, 1);
    check_eq("11_new", new_data, 1'b1);
    check_eq("11_data", data_out, 8'h11);
    @(posedge clk);
    #1;
    fork
      send_frame(8'h22, 1'b1, 1);
      begin
        repeat (5 * CLK_BIT) @(posedge clk);
        #1;
        check_eq("22_mid_data", data_out, 8'h11);
      end
    join
    check_eq("22_new", new_data, 1'b1);
    check_eq("22_data", data_out, 8'h22);

    // Read on the same edge as the stop sample of 0x33
    @(posedge clk);
    #1;
    fork
      send_frame(8'h33, 1'b1, 1);
      begin
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1 read = 1'b1;
        @(posedge clk);
        #1 read = 1'b0;
        check_eq("33_sim_new", new_data, 1'b1);
        check_eq("33_sim_data", data_out, 8'h33);
      end
    join
    check_eq("33_new", new_data, 1'b1);
    check_eq("33_data", data_out, 8'h33);

    // Reset in the middle of a frame (bits 4..7 of 0xF0 keep the line high)
    @(posedge clk);
    #1;
    fork
      send_frame(8'hF0, 1'b1, 1);
      begin
        repeat (5 * CLK_BIT + HALF) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("mrst_data", data_out, 8'h00);
        check_eq("mrst_new", new_data, 1'b0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
      end
    join
    repeat (2 * CLK_BIT) @(posedge clk);
    #1;
    check_eq("mrst_after_new", new_data, 1'b0);
    check_eq("mrst_after_data", data_out, 8'h00);
    send_frame(8'h96, 1'b1, 1);
    check_eq("96_new", new_data, 1'b1);
    check_eq("96_data", data_out, 8'h96);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: deserialises the asynchronous serial line rxd_in into bytes.
- Presents each received byte on data_out and raises new_data until the consumer pulses read.
- Sits between the board RX pin and the CPU I/O register block.
- Default rate: 38400 baud from a 50 MHz clock (1302 clocks per bit).

Parameters:
- CLKS_PER_BIT, 1302, clock cycles per serial bit (50,000,000 / 38,400, truncated).
- HALF_BIT, CLKS_PER_BIT/2 (651), start-bit validation delay; derived, not overridable.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- rxd_in  input  1  serial line, idle high; asynchronous to clk.
- read  input  1  single-cycle acknowledge from the consumer; clears new_data.
- data_out  output  8  last correctly framed byte, LSB received first.
- new_data  output  1  high while data_out holds a byte not yet acknowledged.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counters=0, data_out=8'h00, new_data=0, synchroniser flops=1.
- rxd_in passes through a 2-flop synchroniser (reset value 1). All sampling uses the synchronised signal, which adds 2 cycles of latency.
- IDLE: when the synchronised line is 0, go to START and clear the bit counter.
- START:
  - Count HALF_BIT cycles, then resample.
  - If the line is 0, the start bit is valid: go to DATA with bit index 0.
  - If the line is 1, it was a glitch: return to IDLE; nothing is output.
  - Any low pulse shorter than about 649 cycles is therefore rejected.
- DATA:
  - Every CLKS_PER_BIT cycles, sample the line into shift register bit [index], LSB first.
  - After index 7, go to STOP.
  - Sample points fall at 1.5, 2.5 … 8.5 bit times after the falling edge of the start bit.
- STOP:
  - After CLKS_PER_BIT cycles (9.5 bit times), sample the line.
  - If 1: load data_out with the shift register and set new_data=1 on the same edge, then go to IDLE.
  - If 0 (framing error): discard the byte, leave data_out and new_data unchanged, and go to WAIT_IDLE.
- WAIT_IDLE: stay until the line is 1, then go to IDLE. This prevents a stuck-low line from retriggering.
- read=1 for one cycle clears new_data on the next edge. read while new_data=0 has no effect.
- Byte completes in the same cycle as read=1: the set wins, so new_data stays 1 and data_out holds the new byte.
- Overrun: a new byte completing while new_data=1 overwrites data_out; new_data stays 1. No error flag.
- data_out changes only on a valid stop bit, never mid-reception.
- Reception continues regardless of new_data; the receiver never stalls.
- Reset asserted mid-frame aborts reception immediately. After release, the next falling edge starts a new frame.

Test Plan:
- Reset values: hold rst=0 for 100 ns with rxd_in=1 -> data_out=8'h00, new_data=0. Release rst=1 and hold 1000 cycles idle -> outputs unchanged.
- Glitch rejection: drive rxd_in=0 for 600 cycles, then 1 -> no reception; new_data stays 0 for ≥12,000 cycles.
- Valid byte: send start, then 0xA5 LSB first (1,0,1,0,0,1,0,1), then stop, each bit 1302 cycles -> about 9.5 bit times after the start edge, new_data=1 and data_out=8'hA5. new_data holds until read.
- Read handshake: after the previous case, pulse read=1 for one cycle -> new_data=0 on the next edge, data_out stays 8'hA5. A second read pulse has no effect.
- Framing error: send start, 0x3C, then stop bit=0 held for 2 bit times, then 1 -> new_data remains 0 and data_out unchanged. A following valid 0x5A frame is received correctly.
- Overrun and simultaneous events:
  - Send 0x11 then 0x22 back-to-back without read -> data_out=8'h22, new_data=1.
  - Align a read pulse with the stop-bit sample cycle of a third byte 0x33 -> new_data stays 1 and data_out=8'h33.
